// File: rtl/reverse_buf_pkg.sv
// Shared types and helpers for the ping-pong frame reverser.
// Optional forward-drain feature is controlled by REVERSE_BUF_BYPASS_EN (see reverse_buf.sv).
package reverse_buf_pkg;

    // Per-bank life cycle: fill completely, then drain completely.
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    localparam int NUM_BANKS = 2;

    // Pointer width for a power-of-two frame length.
    function automatic int len_log2(input int len);
        return $clog2(len);
    endfunction

endpackage

// File: rtl/reverse_buf_if.sv
// Streaming input/output handshake bundle for reverse_buf.
// The output sample is named do_data because "do" is a reserved word.
interface reverse_buf_if #(
    parameter int DATA_WIDTH = 25
);
    logic [DATA_WIDTH-1:0] di;
    logic                  di_valid;
    logic                  di_ready;
    logic [DATA_WIDTH-1:0] do_data;
    logic                  do_valid;
    logic                  do_ready;
    logic                  do_last;

    // Buffer side
    modport slave (
        input  di, di_valid, do_ready,
        output di_ready, do_data, do_valid, do_last
    );

    // Source/sink side
    modport master (
        output di, di_valid, do_ready,
        input  di_ready, do_data, do_valid, do_last
    );
endinterface

// File: rtl/reverse_buf_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// No reset on storage or read register so it maps onto block RAM.
module sdp_ram #(
    parameter int DATA_WIDTH = 25,
    parameter int ADDR_W     = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write on we; read register holds its value while re is low.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/reverse_buf.sv
// Streaming frame reverser: ping-pong over two banks of LEN samples, one bank
// fills while the other drains from index LEN-1 down to 0.
// Optional macro REVERSE_BUF_BYPASS_EN adds a `reverse` input sampled at the
// first write of each frame; reverse=0 drains that frame in input order.
module reverse_buf
    import reverse_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 25,
    parameter int LEN        = 512
) (
    input  logic clk,
    input  logic rst,
`ifdef REVERSE_BUF_BYPASS_EN
    input  logic reverse,
`endif
    reverse_buf_if.slave bus
);
    localparam int PTR_W  = len_log2(LEN);
    localparam int ADDR_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(LEN - 1);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    bank_state_t           state_q [NUM_BANKS];
    bank_state_t           state_d [NUM_BANKS];
    logic                  do_valid_q, do_valid_d;
    logic                  do_last_q, do_last_d;
    logic                  wr_en, rd_en;
    logic [PTR_W-1:0]      rd_addr_ptr;
    logic [DATA_WIDTH-1:0] ram_rdata;
`ifdef REVERSE_BUF_BYPASS_EN
    logic                  rev_q [NUM_BANKS];
    logic                  rev_d [NUM_BANKS];
`endif

    // Writer may only enter a bank that has not yet been completely filled.
    assign bus.di_ready = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILLING);
    assign wr_en        = bus.di_valid && bus.di_ready;

    // A read is issued whenever a full bank exists and the output register is free or being taken.
    assign rd_en = ((state_q[rd_bank_q] == FULL) || (state_q[rd_bank_q] == DRAINING))
                   && (!do_valid_q || bus.do_ready);

    // rd_ptr always counts LEN-1 down to 0; a forward frame reads the mirrored index.
`ifdef REVERSE_BUF_BYPASS_EN
    assign rd_addr_ptr = rev_q[rd_bank_q] ? rd_ptr_q : ~rd_ptr_q;
`else
    assign rd_addr_ptr = rd_ptr_q;
`endif

    // Bank state machines, pointers and output-stage control.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_bank_d  = wr_bank_q;
        rd_ptr_d   = rd_ptr_q;
        rd_bank_d  = rd_bank_q;
        do_valid_d = do_valid_q;
        do_last_d  = do_last_q;
`ifdef REVERSE_BUF_BYPASS_EN
        rev_d = rev_q;
        if (wr_en && (state_q[wr_bank_q] == EMPTY)) begin
            rev_d[wr_bank_q] = reverse;
        end
`endif
        // Writer and reader never own the same bank, so their updates do not collide.
        if (wr_en) begin
            if (wr_ptr_q == PTR_MAX) begin
                wr_ptr_d           = '0;
                state_d[wr_bank_q] = FULL;
                wr_bank_d          = ~wr_bank_q;
            end else begin
                wr_ptr_d           = wr_ptr_q + PTR_W'(1);
                state_d[wr_bank_q] = FILLING;
            end
        end
        if (rd_en) begin
            if (rd_ptr_q == '0) begin
                rd_ptr_d           = PTR_MAX;
                state_d[rd_bank_q] = EMPTY;
                rd_bank_d          = ~rd_bank_q;
            end else begin
                rd_ptr_d           = rd_ptr_q - PTR_W'(1);
                state_d[rd_bank_q] = DRAINING;
            end
        end
        if (rd_en) begin
            do_valid_d = 1'b1;
            do_last_d  = (rd_ptr_q == '0);
        end else if (bus.do_ready) begin
            do_valid_d = 1'b0;
        end
    end

    // Control state register; RAM contents and read data are deliberately not reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= PTR_MAX;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            do_valid_q <= 1'b0;
            do_last_q  <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= EMPTY;
`ifdef REVERSE_BUF_BYPASS_EN
                rev_q[b]   <= 1'b1;
`endif
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            do_valid_q <= do_valid_d;
            do_last_q  <= do_last_d;
            state_q    <= state_d;
`ifdef REVERSE_BUF_BYPASS_EN
            rev_q      <= rev_d;
`endif
        end
    end

    sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_bank_q, wr_ptr_q}),
        .wdata (bus.di),
        .re    (rd_en),
        .raddr ({rd_bank_q, rd_addr_ptr}),
        .rdata (ram_rdata)
    );

    // The RAM read register is the output register; it is masked to zero while
    // idle so the output reads 0 out of reset without resetting the RAM itself.
    assign bus.do_data  = do_valid_q ? ram_rdata : '0;
    assign bus.do_valid = do_valid_q;
    assign bus.do_last  = do_last_q;
endmodule

// File: tb/tb_reverse_buf.sv
// Directed testbench for reverse_buf with LEN=8, DATA_WIDTH=25.
module tb_reverse_buf;
    localparam int DW = 25;
    localparam int L  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef REVERSE_BUF_BYPASS_EN
    logic reverse = 1'b1;
    bit   rev_sel [$];
`endif

    reverse_buf_if #(.DATA_WIDTH(DW)) bus ();

    reverse_buf #(.DATA_WIDTH(DW), .LEN(L)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef REVERSE_BUF_BYPASS_EN
        .reverse (reverse),
`endif
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int            src     [$];
    logic [DW-1:0] got_d   [$];
    bit            got_l   [$];
    int            got_cyc [$];
    int            acc_cyc [$];
    int            in_pos;
    int            stall_cnt;
    int            cyc_no;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic clear_stream();
        src.delete(); got_d.delete(); got_l.delete(); got_cyc.delete(); acc_cyc.delete();
        in_pos = 0; stall_cnt = 0; cyc_no = 0;
`ifdef REVERSE_BUF_BYPASS_EN
        rev_sel.delete();
`endif
    endtask

    task automatic drive_inputs(input int in_pct, input int out_pct);
        bit have;
        have          = (in_pos < src.size());
        bus.di_valid  = have && (int'($urandom_range(99)) < in_pct);
        bus.di        = have ? DW'(src[in_pos]) : '0;
        bus.do_ready  = (int'($urandom_range(99)) < out_pct);
`ifdef REVERSE_BUF_BYPASS_EN
        reverse = (in_pos / L < rev_sel.size()) ? rev_sel[in_pos / L] : 1'b1;
`endif
    endtask

    // Runs until n_out outputs collected or budget cycles elapse.
    task automatic run_stream(input int in_pct, input int out_pct, input int n_out, input int budget);
        drive_inputs(in_pct, out_pct);
        for (int c = 0; c < budget && got_d.size() < n_out; c++) begin
            @(negedge clk);
            if (bus.di_valid && !bus.di_ready) stall_cnt++;
            if (bus.di_valid && bus.di_ready) begin
                acc_cyc.push_back(cyc_no);
                in_pos++;
            end
            if (bus.do_valid && bus.do_ready) begin
                got_d.push_back(bus.do_data);
                got_l.push_back(bus.do_last);
                got_cyc.push_back(cyc_no);
            end
            cyc_no++;
            @(posedge clk);
            #1;
            drive_inputs(in_pct, out_pct);
        end
    endtask

    task automatic do_reset();
        bus.di_valid = 1'b0;
        bus.di       = '0;
        bus.do_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_stream();
    endtask

    // Count reversed-frame data/last mismatches of got_* against base + reversed index order.
    function automatic int count_rev_errs(input int base, input int n);
        int errs = 0;
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            int e = base + (i / L) * L + (L - 1 - i % L);
            if (got_d[i] !== DW'(e)) errs++;
            if (got_l[i] !== ((i % L) == L - 1)) errs++;
        end
        return errs;
    endfunction

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (bus.do_valid !== 1'b0) begin failures++; $display("FAIL reset_do_valid got=%b exp=0", bus.do_valid); end
        checks++; if (bus.do_last !== 1'b0) begin failures++; $display("FAIL reset_do_last got=%b exp=0", bus.do_last); end
        checks++; if (bus.do_data !== '0) begin failures++; $display("FAIL reset_do got=%0d exp=0", bus.do_data); end
        checks++; if (bus.di_ready !== 1'b1) begin failures++; $display("FAIL reset_di_ready got=%b exp=1", bus.di_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame();
        do_reset();
        for (int i = 0; i < L; i++) src.push_back(i);
        run_stream(100, 100, L, 60);
        checks++; if (got_d.size() != L) begin failures++; $display("FAIL single_count got=%0d exp=%0d", got_d.size(), L); end
        for (int i = 0; i < L && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== DW'(L - 1 - i)) begin failures++; $display("FAIL single_data[%0d] got=%0d exp=%0d", i, got_d[i], L - 1 - i); end
            checks++; if (got_l[i] !== (i == L - 1)) begin failures++; $display("FAIL single_last[%0d] got=%b exp=%b", i, got_l[i], i == L - 1); end
        end
        if (got_cyc.size() > 0 && acc_cyc.size() == L) begin
            checks++; if (got_cyc[0] - acc_cyc[L-1] != 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", got_cyc[0] - acc_cyc[L-1]); end
        end else begin
            checks++; failures++; $display("FAIL single_latency got=no_data exp=2");
        end
        run_stream(100, 100, L + 1, 6);
        checks++; if (got_d.size() != L) begin failures++; $display("FAIL single_no_extra got=%0d exp=%0d", got_d.size(), L); end
    endtask

    task automatic test_continuous();
        int gaps;
        do_reset();
        for (int i = 0; i < 3 * L; i++) src.push_back(i);
        run_stream(100, 100, 3 * L, 100);
        checks++; if (got_d.size() != 3 * L) begin failures++; $display("FAIL cont_count got=%0d exp=%0d", got_d.size(), 3 * L); end
        checks++; if (count_rev_errs(0, 3 * L) != 0) begin failures++; $display("FAIL cont_data got=%0d_errors exp=0", count_rev_errs(0, 3 * L)); end
        checks++; if (stall_cnt != 0) begin failures++; $display("FAIL cont_di_ready stalls got=%0d exp=0", stall_cnt); end
        gaps = 0;
        for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] != got_cyc[i-1] + 1) gaps++;
        checks++; if (gaps != 0) begin failures++; $display("FAIL cont_gaps got=%0d exp=0", gaps); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 3 * L; i++) src.push_back(i);
        run_stream(100, 0, 1000, 30);
        @(negedge clk);
        checks++; if (acc_cyc.size() != 2 * L) begin failures++; $display("FAIL bp_accepted got=%0d exp=%0d", acc_cyc.size(), 2 * L); end
        checks++; if (bus.di_ready !== 1'b0) begin failures++; $display("FAIL bp_di_ready got=%b exp=0", bus.di_ready); end
        checks++; if (bus.do_valid !== 1'b1) begin failures++; $display("FAIL bp_do_valid got=%b exp=1", bus.do_valid); end
        checks++; if (bus.do_data !== DW'(L - 1)) begin failures++; $display("FAIL bp_do_held got=%0d exp=%0d", bus.do_data, L - 1); end
        @(posedge clk); #1;
        run_stream(100, 0, 1000, 5);
        @(negedge clk);
        checks++; if (bus.do_data !== DW'(L - 1) || bus.do_valid !== 1'b1) begin failures++; $display("FAIL bp_do_stable got=%0d/%b exp=%0d/1", bus.do_data, bus.do_valid, L - 1); end
        @(posedge clk); #1;
        run_stream(100, 100, 3 * L, 100);
        checks++; if (got_d.size() != 3 * L) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_d.size(), 3 * L); end
        checks++; if (count_rev_errs(0, 3 * L) != 0) begin failures++; $display("FAIL bp_data got=%0d_errors exp=0", count_rev_errs(0, 3 * L)); end
    endtask

    task automatic test_random();
        int nlast;
        do_reset();
        for (int i = 0; i < 1000 * L; i++) src.push_back(i);
        run_stream(70, 60, 1000 * L, 40000);
        checks++; if (got_d.size() != 1000 * L) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_d.size(), 1000 * L); end
        checks++; if (count_rev_errs(0, 1000 * L) != 0) begin failures++; $display("FAIL rand_data got=%0d_errors exp=0", count_rev_errs(0, 1000 * L)); end
        nlast = 0;
        foreach (got_l[i]) if (got_l[i]) nlast++;
        checks++; if (nlast != 1000) begin failures++; $display("FAIL rand_last_count got=%0d exp=1000", nlast); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 2 * L; i++) src.push_back(i);
        run_stream(100, 100, L + 3, 80);
        checks++; if (got_d.size() != L + 3) begin failures++; $display("FAIL rstmid_pre got=%0d exp=%0d", got_d.size(), L + 3); end
        bus.di_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.do_valid !== 1'b0) begin failures++; $display("FAIL rstmid_do_valid got=%b exp=0", bus.do_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_stream();
        @(negedge clk);
        checks++; if (bus.di_ready !== 1'b1) begin failures++; $display("FAIL rstmid_di_ready got=%b exp=1", bus.di_ready); end
        @(posedge clk); #1;
        for (int i = 0; i < L; i++) src.push_back(100 + i);
        run_stream(100, 100, L + 1, 40);
        checks++; if (got_d.size() != L) begin failures++; $display("FAIL rstmid_count got=%0d exp=%0d", got_d.size(), L); end
        checks++; if (count_rev_errs(100, L) != 0) begin failures++; $display("FAIL rstmid_data got=%0d_errors exp=0", count_rev_errs(100, L)); end
    endtask

`ifdef REVERSE_BUF_BYPASS_EN
    task automatic test_bypass();
        int errs;
        do_reset();
        rev_sel.push_back(1'b0);
        rev_sel.push_back(1'b1);
        for (int i = 0; i < 2 * L; i++) src.push_back(i);
        run_stream(100, 100, 2 * L, 80);
        checks++; if (got_d.size() != 2 * L) begin failures++; $display("FAIL byp_count got=%0d exp=%0d", got_d.size(), 2 * L); end
        errs = 0;
        for (int i = 0; i < got_d.size(); i++) begin
            int e = (i < L) ? i : (2 * L - 1 - (i - L));
            if (got_d[i] !== DW'(e)) errs++;
            if (got_l[i] !== ((i % L) == L - 1)) errs++;
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL byp_data got=%0d_errors exp=0", errs); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_continuous();
        test_backpressure();
        test_random();
        test_reset_mid_drain();
`ifdef REVERSE_BUF_BYPASS_EN
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
